// File: rtl/mem_arbiter2.sv
// Two-master arbiter for the shared SDRAM valid/ready port.
// Registered grant, captured request fields, and a watchdog that forces an error completion.
module mem_arbiter2 #(
  parameter int AW           = 32,
  parameter int CPU_PRIORITY = 0,
  parameter int TIMEOUT      = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_din,
  input  logic [3:0]    m0_lane,
  input  logic          m0_wr,
  input  logic          m0_valid,
  output logic          m0_ready,
  output logic [31:0]   m0_dout,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_din,
  input  logic [3:0]    m1_lane,
  input  logic          m1_wr,
  input  logic          m1_valid,
  output logic          m1_ready,
  output logic [31:0]   m1_dout,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_din,
  output logic [3:0]    s_lane,
  output logic          s_wr,
  output logic          s_valid,
  input  logic          s_ready,
  input  logic [31:0]   s_dout,
  output logic [1:0]    owner,
  output logic          timeout_err
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  // The encoding doubles as the owner code: 00 none, 01 m0, 10 m1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t         state, state_d;
  logic           last_grant_m1;
  logic [WDW-1:0] wd;
  logic           busy, expire, done, grant_m0, grant_m1;

  always_comb begin
    state_d  = state;
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    busy     = (state != IDLE);
    expire   = (TIMEOUT > 0) && busy && !s_ready && (wd == WDW'(TIMEOUT - 1));
    done     = busy && (s_ready || expire);
    case (state)
      IDLE: begin
        // m0 takes a tie under fixed priority, or when m1 was the last winner.
        if (m0_valid && (!m1_valid || (CPU_PRIORITY != 0) || last_grant_m1)) begin
          grant_m0 = 1'b1;
          state_d  = GRANT0;
        end else if (m1_valid) begin
          grant_m1 = 1'b1;
          state_d  = GRANT1;
        end
      end
      default: begin
        if (done) state_d = IDLE;
      end
    endcase
  end

  assign s_valid  = busy;
  assign owner    = state;
  assign m0_ready = (state == GRANT0) && done;
  assign m1_ready = (state == GRANT1) && done;
  assign m0_dout  = ((state == GRANT0) && expire) ? 32'hFFFF_FFFF : s_dout;
  assign m1_dout  = ((state == GRANT1) && expire) ? 32'hFFFF_FFFF : s_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_addr        <= '0;
      s_din         <= '0;
      s_lane        <= '0;
      s_wr          <= 1'b0;
      last_grant_m1 <= 1'b1;
      wd            <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_d;
      if (grant_m0 || grant_m1) begin
        s_addr        <= grant_m0 ? m0_addr : m1_addr;
        s_din         <= grant_m0 ? m0_din  : m1_din;
        s_lane        <= grant_m0 ? m0_lane : m1_lane;
        s_wr          <= grant_m0 ? m0_wr   : m1_wr;
        last_grant_m1 <= grant_m1;
        wd            <= '0;
      end else if (busy && !done) begin
        wd <= wd + WDW'(1);
      end
      if (expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: a round-robin instance with an 8-cycle watchdog and a
// fixed-priority instance with no watchdog, both driven by the same masters and slave.
module tb_mem_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr, m0_din, m1_addr, m1_din, s_dout;
  logic [3:0]  m0_lane, m1_lane;
  logic        m0_wr, m0_valid, m1_wr, m1_valid, s_ready;

  logic        a_m0_ready, a_m1_ready, a_s_wr, a_s_valid, a_timeout_err;
  logic [31:0] a_m0_dout, a_m1_dout, a_s_addr, a_s_din;
  logic [3:0]  a_s_lane;
  logic [1:0]  a_owner;
  logic        b_m0_ready, b_m1_ready, b_s_wr, b_s_valid, b_timeout_err;
  logic [31:0] b_m0_dout, b_m1_dout, b_s_addr, b_s_din;
  logic [3:0]  b_s_lane;
  logic [1:0]  b_owner;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter2 #(.AW(32), .CPU_PRIORITY(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_lane(m0_lane), .m0_wr(m0_wr),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_dout(a_m0_dout),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_lane(m1_lane), .m1_wr(m1_wr),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_dout(a_m1_dout),
    .s_addr(a_s_addr), .s_din(a_s_din), .s_lane(a_s_lane), .s_wr(a_s_wr),
    .s_valid(a_s_valid), .s_ready(s_ready), .s_dout(s_dout),
    .owner(a_owner), .timeout_err(a_timeout_err));

  mem_arbiter2 #(.AW(32), .CPU_PRIORITY(1), .TIMEOUT(0)) dut_pri (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_lane(m0_lane), .m0_wr(m0_wr),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_dout(b_m0_dout),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_lane(m1_lane), .m1_wr(m1_wr),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_dout(b_m1_dout),
    .s_addr(b_s_addr), .s_din(b_s_din), .s_lane(b_s_lane), .s_wr(b_s_wr),
    .s_valid(b_s_valid), .s_ready(s_ready), .s_dout(s_dout),
    .owner(b_owner), .timeout_err(b_timeout_err));

  // Transaction-level model: who owns the slave, for how many cycles, what was captured.
  int          own_m  [2];
  int          age_m  [2];
  bit          last_m1[2];
  logic [31:0] addr_m [2];
  logic [31:0] din_m  [2];
  logic [3:0]  lane_m [2];
  bit          wr_m   [2];
  bit          err_m  [2];

  function automatic int prio_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int tmo_of(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic int pick(input int i);
    if (m0_valid && m1_valid) return (prio_of(i) != 0 || last_m1[i]) ? 1 : 2;
    if (m0_valid) return 1;
    if (m1_valid) return 2;
    return 0;
  endfunction

  function automatic bit model_done(input int i);
    return (own_m[i] != 0) && (s_ready || (tmo_of(i) > 0 && age_m[i] == tmo_of(i) - 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        own_m[i] <= 0; age_m[i] <= 0; last_m1[i] <= 1'b1;
        addr_m[i] <= '0; din_m[i] <= '0; lane_m[i] <= '0; wr_m[i] <= 1'b0; err_m[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (own_m[i] == 0) begin
          if (pick(i) != 0) begin
            own_m[i]   <= pick(i);
            age_m[i]   <= 0;
            last_m1[i] <= (pick(i) == 2);
            addr_m[i]  <= (pick(i) == 1) ? m0_addr : m1_addr;
            din_m[i]   <= (pick(i) == 1) ? m0_din  : m1_din;
            lane_m[i]  <= (pick(i) == 1) ? m0_lane : m1_lane;
            wr_m[i]    <= (pick(i) == 1) ? m0_wr   : m1_wr;
          end
        end else if (model_done(i)) begin
          own_m[i] <= 0;
          if (!s_ready) err_m[i] <= 1'b1;
        end else begin
          age_m[i] <= age_m[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_inst(input int i, input logic sv, input logic [1:0] own,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic [3:0] lane, input logic wr,
                              input logic m0r, input logic m1r,
                              input logic [31:0] m0d, input logic [31:0] m1d,
                              input logic terr);
    bit          done;
    logic [31:0] rdat;
    done = model_done(i);
    rdat = s_ready ? s_dout : 32'hFFFF_FFFF;
    checkOutput($sformatf("i%0d s_valid", i), 32'(sv), 32'(own_m[i] != 0));
    checkOutput($sformatf("i%0d owner", i), 32'(own), 32'(own_m[i]));
    checkOutput($sformatf("i%0d s_addr", i), addr, addr_m[i]);
    checkOutput($sformatf("i%0d s_din", i), din, din_m[i]);
    checkOutput($sformatf("i%0d s_lane", i), 32'(lane), 32'(lane_m[i]));
    checkOutput($sformatf("i%0d s_wr", i), 32'(wr), 32'(wr_m[i]));
    checkOutput($sformatf("i%0d m0_ready", i), 32'(m0r), 32'(done && own_m[i] == 1));
    checkOutput($sformatf("i%0d m1_ready", i), 32'(m1r), 32'(done && own_m[i] == 2));
    if (done && own_m[i] == 1) checkOutput($sformatf("i%0d m0_dout", i), m0d, rdat);
    if (done && own_m[i] == 2) checkOutput($sformatf("i%0d m1_dout", i), m1d, rdat);
    checkOutput($sformatf("i%0d timeout_err", i), 32'(terr), 32'(err_m[i]));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      compare_inst(0, a_s_valid, a_owner, a_s_addr, a_s_din, a_s_lane, a_s_wr,
                   a_m0_ready, a_m1_ready, a_m0_dout, a_m1_dout, a_timeout_err);
      compare_inst(1, b_s_valid, b_owner, b_s_addr, b_s_din, b_s_lane, b_s_wr,
                   b_m0_ready, b_m1_ready, b_m0_dout, b_m1_dout, b_timeout_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [3:0] l0, input logic w0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic [3:0] l1, input logic w1);
    m0_valid = v0; m0_addr = a0; m0_din = d0; m0_lane = l0; m0_wr = w0;
    m1_valid = v1; m1_addr = a1; m1_din = d1; m1_lane = l1; m1_wr = w1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns at the falling edge of the first cycle in which the round-robin instance holds a grant.
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (a_s_valid === 1'b1) break;
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s: got no grant, expected one within 40 cycles", name);
    end
  endtask

  int exp_rr[4] = '{1, 2, 1, 2};

  initial begin
    rst_n = 1'b0;
    s_ready = 1'b0;
    s_dout = '0;
    applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    tick();
    tick();
    checkOutput("reset s_valid", 32'(a_s_valid), 32'd0);
    checkOutput("reset owner", 32'(a_owner), 32'd0);
    checkOutput("reset s_addr", a_s_addr, 32'd0);
    checkOutput("reset m0_ready", 32'(a_m0_ready), 32'd0);
    checkOutput("reset timeout_err", 32'(a_timeout_err), 32'd0);
    rst_n = 1'b1;

    // Single m0 read: grant in cycle 1, slave answers in cycle 3.
    applyStimulus(1, 32'h8000_0010, '0, 4'hF, 0, 0, '0, '0, '0, 0);
    tick();
    @(negedge clk);
    checkOutput("t1 s_valid c1", 32'(a_s_valid), 32'd1);
    checkOutput("t1 owner c1", 32'(a_owner), 32'd1);
    checkOutput("t1 s_addr", a_s_addr, 32'h8000_0010);
    checkOutput("t1 m0_ready c1", 32'(a_m0_ready), 32'd0);
    tick();
    tick();
    s_ready = 1'b1; s_dout = 32'h1234_5678;
    @(negedge clk);
    checkOutput("t1 m0_ready c3", 32'(a_m0_ready), 32'd1);
    checkOutput("t1 m0_dout c3", a_m0_dout, 32'h1234_5678);
    checkOutput("t1 pri m0_ready c3", 32'(b_m0_ready), 32'd1);
    tick();
    s_ready = 1'b0; m0_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1 s_valid c4", 32'(a_s_valid), 32'd0);

    // Both masters write continuously: round-robin alternates, fixed priority always picks m0.
    pulse_reset();
    applyStimulus(1, 32'h0000_1000, 32'hAAAA_0000, 4'hF, 1, 1, 32'h0000_2000, 32'h5555_1111, 4'h3, 1);
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2 grant");
      checkOutput($sformatf("t2 rr owner %0d", k), 32'(a_owner), 32'(exp_rr[k]));
      checkOutput($sformatf("t2 pri owner %0d", k), 32'(b_owner), 32'd1);
      checkOutput($sformatf("t2 rr s_din %0d", k), a_s_din, (exp_rr[k] == 1) ? 32'hAAAA_0000 : 32'h5555_1111);
      checkOutput($sformatf("t2 rr s_lane %0d", k), 32'(a_s_lane), (exp_rr[k] == 1) ? 32'hF : 32'h3);
      tick();
      s_ready = 1'b1; s_dout = 32'(k);
      @(negedge clk);
      checkOutput($sformatf("t2 rr ready %0d", k),
                  32'((exp_rr[k] == 1) ? a_m0_ready : a_m1_ready), 32'd1);
      tick();
      s_ready = 1'b0;
    end
    applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);

    // Owner changes its address and drops valid mid-grant; capture must hold.
    applyStimulus(1, 32'h0000_3000, '0, 4'h1, 0, 0, '0, '0, '0, 0);
    wait_grant("t3 grant");
    tick();
    m0_addr = 32'h0000_3FFF; m0_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3 s_addr held", a_s_addr, 32'h0000_3000);
    checkOutput("t3 s_valid held", 32'(a_s_valid), 32'd1);
    tick();
    s_ready = 1'b1; s_dout = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("t3 m0_ready", 32'(a_m0_ready), 32'd1);
    checkOutput("t3 m0_dout", a_m0_dout, 32'hCAFE_F00D);
    tick();
    s_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3 m0_ready after", 32'(a_m0_ready), 32'd0);

    // s_ready in the 8th grant cycle beats the watchdog.
    pulse_reset();
    applyStimulus(0, '0, '0, '0, 0, 1, 32'h0000_4000, '0, 4'hF, 0);
    wait_grant("t4a grant");
    repeat (7) tick();
    s_ready = 1'b1; s_dout = 32'h600D_DA7A;
    @(negedge clk);
    checkOutput("t4a m1_ready", 32'(a_m1_ready), 32'd1);
    checkOutput("t4a m1_dout", a_m1_dout, 32'h600D_DA7A);
    tick();
    s_ready = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4a timeout_err", 32'(a_timeout_err), 32'd0);

    // Slave never answers: watchdog completes in the 8th grant cycle with all-ones.
    applyStimulus(0, '0, '0, '0, 0, 1, 32'h0000_5000, '0, 4'hF, 0);
    wait_grant("t4b grant");
    repeat (7) tick();
    @(negedge clk);
    checkOutput("t4b m1_ready", 32'(a_m1_ready), 32'd1);
    checkOutput("t4b m1_dout", a_m1_dout, 32'hFFFF_FFFF);
    tick();
    m1_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4b timeout_err set", 32'(a_timeout_err), 32'd1);
    checkOutput("t4b s_valid dropped", 32'(a_s_valid), 32'd0);
    checkOutput("t4b pri still waiting", 32'(b_s_valid), 32'd1);
    tick();
    s_ready = 1'b1; s_dout = 32'h0;
    tick();
    s_ready = 1'b0;

    // A later good transaction leaves the sticky error set.
    applyStimulus(1, 32'h0000_6000, '0, 4'hF, 0, 0, '0, '0, '0, 0);
    wait_grant("t4c grant");
    tick();
    s_ready = 1'b1; s_dout = 32'h1111_2222;
    @(negedge clk);
    checkOutput("t4c m0_dout", a_m0_dout, 32'h1111_2222);
    checkOutput("t4c timeout_err sticky", 32'(a_timeout_err), 32'd1);
    tick();
    s_ready = 1'b0; m0_valid = 1'b0;

    // Asynchronous reset while m1 owns the slave.
    applyStimulus(0, '0, '0, '0, 0, 1, 32'h0000_7000, '0, 4'hF, 1);
    wait_grant("t5 grant");
    checkOutput("t5 owner before reset", 32'(a_owner), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 s_valid in reset", 32'(a_s_valid), 32'd0);
    checkOutput("t5 owner in reset", 32'(a_owner), 32'd0);
    checkOutput("t5 timeout_err in reset", 32'(a_timeout_err), 32'd0);
    checkOutput("t5 pri s_valid in reset", 32'(b_s_valid), 32'd0);
    m1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 32'h0000_8000, '0, 4'hF, 0, 1, 32'h0000_9000, '0, 4'hF, 0);
    wait_grant("t5 regrant");
    checkOutput("t5 first tie to m0", 32'(a_owner), 32'd1);
    tick();
    s_ready = 1'b1; s_dout = 32'h0BAD_BEEF;
    tick();
    s_ready = 1'b0;
    applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global watchdog: got no end of test, expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter that shares the single valid/ready memory port of the SDRAM controller between the CPU and a second bus master (DMA/blitter). Sits between the CPU address decode (sdram_area path) and the SDRAM controller's cpu-side port. Provides:
- one-cycle registered arbitration, round-robin or fixed priority;
- request capture, so the slave sees stable signals for the whole transaction;
- a timeout watchdog that completes a hung access with an error response.

## Interface
- AW, 32, address width of masters and slave.
- CPU_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = m0 always wins ties.
- TIMEOUT, 1024, cycles in a grant state without s_ready before forced completion; 0 disables the watchdog.

- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_addr  in  AW  master 0 (CPU) address.
- m0_din  in  32  master 0 write data.
- m0_lane  in  4  master 0 byte enables.
- m0_wr  in  1  master 0 write (1) / read (0).
- m0_valid  in  1  master 0 request.
- m0_ready  out  1  master 0 completion pulse.
- m0_dout  out  32  master 0 read data, valid while m0_ready=1.
- m1_addr, m1_din, m1_lane, m1_wr, m1_valid, m1_ready, m1_dout: same as m0_*, for master 1 (DMA).
- s_addr  out  AW  captured address to slave.
- s_din  out  32  captured write data to slave.
- s_lane  out  4  captured byte enables.
- s_wr  out  1  captured write flag.
- s_valid  out  1  request to slave.
- s_ready  in  1  slave completion pulse.
- s_dout  in  32  slave read data.
- owner  out  2  current owner: 00 = none, 01 = m0, 10 = m1.
- timeout_err  out  1  sticky; set on any watchdog expiry.

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE, arbitration:
  - Only one m_valid high: grant that master.
  - Both high, CPU_PRIORITY=1: grant m0.
  - Both high, CPU_PRIORITY=0: grant the master not granted last. last_grant resets to m1, so m0 wins the first tie.
- On the grant edge:
  - Capture the winner's addr/din/lane/wr into the s_* registers.
  - Set s_valid=1, load the watchdog counter with 0, update last_grant.
- GRANTx:
  - s_valid and all s_* fields are held constant; m_valid and m_* inputs are ignored until completion, even if the master drops valid.
  - Non-owner requests are not dropped; they are served in a later IDLE as long as that master keeps valid high.
- Normal completion, s_ready=1 in GRANTx:
  - mx_ready=1 combinationally in the same cycle; mx_dout = s_dout.
  - Next state IDLE; s_valid cleared on that edge.
- Watchdog (TIMEOUT>0): the counter increments each GRANTx cycle with s_ready=0. When counter = TIMEOUT-1:
  - mx_ready=1, mx_dout=32'hFFFFFFFF, timeout_err <= 1.
  - Next state IDLE, s_valid cleared.
- s_ready and timeout in the same cycle: s_ready wins; real data returned, timeout_err unchanged.
- The non-owner's ready is always 0. Its dout mirrors s_dout and is meaningless.
- s_ready while IDLE is ignored.
- Master rule: deassert m_valid in the cycle after m_ready unless issuing a new request. Any m_valid sampled high in IDLE is treated as a new request.

## Timing
- Reset (async) clears:
  - state=IDLE, owner=00, s_valid=0, s_addr/s_din/s_lane/s_wr=0;
  - m0_ready=m1_ready=0, timeout_err=0, watchdog=0, last_grant=m1.
- m_dout follows s_dout combinationally; it equals 0 only if the slave drives 0.
- Reset asserted mid-transaction drops s_valid immediately. The slave must tolerate an abandoned request, because the SDRAM controller shares this reset.
- Arbitration latency: m_valid high at edge N (in IDLE) gives s_valid=1 and owner set from edge N+1.
- Completion: s_ready at cycle K gives m_ready at K and s_valid=0 from edge K+1.
- s_valid is low for at least one cycle between transactions, and the earliest next grant is edge K+2.
- Back-to-back throughput: one access per (slave latency + 2) cycles.
- Watchdog: with no s_ready, m_ready is asserted in the TIMEOUT-th cycle after the grant edge.
- Watchdog counter width: clog2(TIMEOUT)+1; it never wraps because it is reset on every grant.

## Test plan
- Single m0 read: m0_valid at edge 0, addr 0x8000_0010, slave s_ready at cycle 3 with s_dout 0x1234_5678 -> s_valid=1 cycles 1–3, s_addr=0x8000_0010, m0_ready=1 only at cycle 3, m0_dout=0x1234_5678, s_valid=0 at cycle 4.
- Simultaneous m0/m1 writes, CPU_PRIORITY=0, repeated 4 times with both held -> grants alternate m0,m1,m0,m1; s_din/s_lane match each owner; m1 never starved. With CPU_PRIORITY=1 and both valid continuously, m0 wins every IDLE.
- Owner m0 changes m0_addr and drops m0_valid mid-grant -> s_addr and s_valid unchanged until s_ready; m0_ready still pulses once.
- TIMEOUT=8, slave never asserts s_ready -> m1_ready=1 with m1_dout=0xFFFF_FFFF at the 8th grant cycle; timeout_err=1 and stays 1 across later good transactions; s_ready coinciding with the 8th cycle returns real data with timeout_err=0.
- rst_n pulsed low while in GRANT1 -> same-cycle s_valid=0, owner=00, timeout_err=0; after release, a simultaneous request goes to m0 first.
